student_iis_frame_gen: RTL and testbench
========================================

STUDENT_IIS_FRAME_GEN -- requirements
Module: student_iis_frame_gen

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 16, data bits per slot.
REQ-002 SHALL have parameter SLOT_WIDTH, default 16, BCLK periods per slot (>= DATA_SIZE).
REQ-003 SHALL have parameter NUM_SLOTS, default 2, slots per frame (even, >= 2).
REQ-004 SHALL have parameter BCLK_DIV, default 8, clk_i cycles per BCLK period (even, >= 2).
REQ-005 SHALL have parameter MCLK_DIV, default 2, clk_i cycles per MCLK period (even, >= 2).
REQ-006 SHALL have parameter CNT_W, default 16, latency counter width.
REQ-007 SHALL have one clock; reset is asynchronous and active-low: clk_i  in  1  system clock; rst_ni  in  1  async active-low reset.
REQ-008 en_i  in  1  run enable.
REQ-009 valid_strobe_out_i  in  1  FIR result-ready pulse.
REQ-010 lat_clr_i  in  1  clear latency statistics.
REQ-011 ac_mclk_o, ac_bclk_o, ac_lrclk_o  out  1 each  codec clocks.
REQ-012 bclk_rise_o, bclk_fall_o, lrclk_rise_o, lrclk_fall_o  out  1 each  single-cycle edge strobes.
REQ-013 slot_idx_o  out  $clog2(NUM_SLOTS)  current slot; bit_idx_o  out  $clog2(SLOT_WIDTH)  current bit in slot.
REQ-014 sample_valid_o  out  1  frame-start pulse to FIR valid_strobe_in.
REQ-015 lat_last_o, lat_max_o  out  CNT_W  last/max measured latency; busy_o  out  1  measurement running; overrun_o  out  1  sticky overrun.

Function
REQ-016 All outputs SHALL be registered; clocks and strobes change in the same clk_i cycle as the edge they describe.
REQ-017 en_i low: dividers, bit, slot counters SHALL hold 0; all clock outputs and strobes 0.
REQ-018 ac_mclk_o SHALL toggle every MCLK_DIV/2 cycles while enabled, first rise one cycle after en_i seen high.
REQ-019 ac_bclk_o SHALL be low for the first BCLK_DIV/2 cycles of each BCLK period, high for the rest; bclk_fall_o pulses at period start, bclk_rise_o at mid-period.
REQ-020 bit_idx_o SHALL advance on every bclk_fall_o, wrapping SLOT_WIDTH-1 -> 0 and then advancing slot_idx_o, wrapping NUM_SLOTS-1 -> 0.
REQ-021 ac_lrclk_o SHALL be 0 for slots 0..NUM_SLOTS/2-1, 1 otherwise, switching at the bclk_fall_o starting the last bit before the boundary (one-BCLK I2S lead); lrclk_rise_o/lrclk_fall_o pulse in that cycle.
REQ-022 sample_valid_o SHALL pulse one cycle with the bclk_fall_o that starts slot 0 bit 0; first pulse one full frame after enable (no partial frame).
REQ-023 Latency: on sample_valid_o, counter SHALL load 0 and busy_o set; counter increments each cycle while busy, saturating at 2^CNT_W-1.
REQ-024 valid_strobe_out_i while busy SHALL write lat_last_o = counter+1, update lat_max_o if greater, clear busy_o; valid_strobe_out_i while idle SHALL be ignored.
REQ-025 sample_valid_o while busy without simultaneous valid_strobe_out_i SHALL set overrun_o and restart measurement.
REQ-026 Simultaneous valid_strobe_out_i and sample_valid_o SHALL record completion then restart; no overrun.
REQ-027 lat_clr_i SHALL zero lat_last_o, lat_max_o, overrun_o next cycle, taking priority over a same-cycle completion; busy_o unaffected.
REQ-028 en_i falling mid-frame SHALL abort measurement (busy_o 0) and retain lat_last_o, lat_max_o, overrun_o.

Reset
REQ-029 rst_ni low SHALL asynchronously force all outputs and internal counters to 0, including mid-frame and mid-measurement.

Verification
REQ-030 Defaults, en_i high: ac_bclk_o period 8 cycles, ac_mclk_o period 2, sample_valid_o every 256 cycles, first at cycle 256 after enable.
REQ-031 ac_lrclk_o rises at bclk_fall_o of slot 0 bit 15, falls at slot 1 bit 15; exactly one lrclk_rise_o and lrclk_fall_o per frame.
REQ-032 valid_strobe_out_i 37 cycles after sample_valid_o -> lat_last_o=37, lat_max_o=37; next 20 -> lat_last_o=20, lat_max_o=37.
REQ-033 No valid_strobe_out_i over one frame -> overrun_o=1 at next sample_valid_o; lat_clr_i -> overrun_o=0, lat_max_o=0.
REQ-034 NUM_SLOTS=4, SLOT_WIDTH=24, BCLK_DIV=4: frame 384 cycles, ac_lrclk_o high for slots 2-3 with one-BCLK lead.
REQ-035 rst_ni low mid-frame while busy -> all outputs 0 immediately; after release and en_i, first sample_valid_o one full frame later.

Source files
------------

// File: rtl/student_iis_frame_gen.sv
// student_iis_frame_gen: I2S codec clock/frame generator with FIR latency monitor
module student_iis_frame_gen #(
    parameter int DATA_SIZE  = 16,
    parameter int SLOT_WIDTH = 16,
    parameter int NUM_SLOTS  = 2,
    parameter int BCLK_DIV   = 8,
    parameter int MCLK_DIV   = 2,
    parameter int CNT_W      = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          en_i,
    input  logic                          valid_strobe_out_i,
    input  logic                          lat_clr_i,
    output logic                          ac_mclk_o,
    output logic                          ac_bclk_o,
    output logic                          ac_lrclk_o,
    output logic                          bclk_rise_o,
    output logic                          bclk_fall_o,
    output logic                          lrclk_rise_o,
    output logic                          lrclk_fall_o,
    output logic [$clog2(NUM_SLOTS)-1:0]  slot_idx_o,
    output logic [$clog2(SLOT_WIDTH)-1:0] bit_idx_o,
    output logic                          sample_valid_o,
    output logic [CNT_W-1:0]              lat_last_o,
    output logic [CNT_W-1:0]              lat_max_o,
    output logic                          busy_o,
    output logic                          overrun_o
);
    localparam int BW     = $clog2(BCLK_DIV);
    localparam int MW     = $clog2(MCLK_DIV);
    localparam int BIT_W  = $clog2(SLOT_WIDTH);
    localparam int SLOT_W = $clog2(NUM_SLOTS);
    localparam logic [BW-1:0]     BD_LAST   = BW'(BCLK_DIV - 1);
    localparam logic [BW-1:0]     BD_HALF   = BW'(BCLK_DIV / 2);
    localparam logic [MW-1:0]     MD_LAST   = MW'(MCLK_DIV / 2 - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(SLOT_WIDTH - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_SLOTS - 1);
    localparam logic [SLOT_W-1:0] SLOT_HALF = SLOT_W'(NUM_SLOTS / 2);

    if (SLOT_WIDTH < DATA_SIZE || NUM_SLOTS < 2 || NUM_SLOTS % 2 != 0 || BCLK_DIV < 2 ||
        BCLK_DIV % 2 != 0 || MCLK_DIV < 2 || MCLK_DIV % 2 != 0) begin : g_bad_params
        $error("student_iis_frame_gen: illegal parameter set");
    end

    logic              run_q, step, bwrap, mwrap, mclk_n, lr_n, done;
    logic [BW-1:0]     bdiv_q, bdiv_n;
    logic [MW-1:0]     mdiv_q, mdiv_n;
    logic [BIT_W-1:0]  bit_n;
    logic [SLOT_W-1:0] slot_n, nxt_slot;
    logic [CNT_W-1:0]  cnt_q, lat_n;

    assign done  = en_i && busy_o && valid_strobe_out_i;
    assign lat_n = &cnt_q ? cnt_q : cnt_q + 1'b1;

    // next divider/bit/slot position; first enabled cycle starts from zero without an edge
    always_comb begin
        step     = en_i && run_q;
        bwrap    = bdiv_q == BD_LAST;
        mwrap    = mdiv_q == MD_LAST;
        bdiv_n   = step && !bwrap ? bdiv_q + 1'b1 : '0;
        mdiv_n   = step && !mwrap ? mdiv_q + 1'b1 : '0;
        mclk_n   = en_i && (!run_q || (mwrap ? !ac_mclk_o : ac_mclk_o));
        bit_n    = !step ? '0 : !bwrap ? bit_idx_o : bit_idx_o == BIT_LAST ? '0 : bit_idx_o + 1'b1;
        slot_n   = !step ? '0 : !(bwrap && bit_idx_o == BIT_LAST) ? slot_idx_o :
                   slot_idx_o == SLOT_LAST ? '0 : slot_idx_o + 1'b1;
        nxt_slot = bit_n != BIT_LAST ? slot_n : slot_n == SLOT_LAST ? '0 : slot_n + 1'b1;
        lr_n     = en_i && nxt_slot >= SLOT_HALF;
    end

    // registered codec clocks, edge strobes and frame position (lrclk follows the next bit's slot)
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_q          <= 1'b0;
            bdiv_q         <= '0;
            mdiv_q         <= '0;
            bit_idx_o      <= '0;
            slot_idx_o     <= '0;
            ac_mclk_o      <= 1'b0;
            ac_bclk_o      <= 1'b0;
            ac_lrclk_o     <= 1'b0;
            bclk_rise_o    <= 1'b0;
            bclk_fall_o    <= 1'b0;
            lrclk_rise_o   <= 1'b0;
            lrclk_fall_o   <= 1'b0;
            sample_valid_o <= 1'b0;
        end else begin
            run_q          <= en_i;
            bdiv_q         <= bdiv_n;
            mdiv_q         <= mdiv_n;
            bit_idx_o      <= bit_n;
            slot_idx_o     <= slot_n;
            ac_mclk_o      <= mclk_n;
            ac_bclk_o      <= en_i && bdiv_n >= BD_HALF;
            bclk_rise_o    <= en_i && bdiv_n == BD_HALF;
            bclk_fall_o    <= step && bdiv_n == '0;
            ac_lrclk_o     <= lr_n;
            lrclk_rise_o   <= lr_n && !ac_lrclk_o;
            lrclk_fall_o   <= en_i && !lr_n && ac_lrclk_o;
            sample_valid_o <= step && bdiv_n == '0 && bit_n == '0 && slot_n == '0;
        end
    end

    // latency from frame start to FIR result, with overrun detection and clearable statistics
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= '0;
            busy_o     <= 1'b0;
            lat_last_o <= '0;
            lat_max_o  <= '0;
            overrun_o  <= 1'b0;
        end else begin
            cnt_q      <= !en_i || sample_valid_o ? '0 : busy_o ? lat_n : cnt_q;
            busy_o     <= en_i && (sample_valid_o || (busy_o && !valid_strobe_out_i));
            lat_last_o <= lat_clr_i ? '0 : done ? lat_n : lat_last_o;
            lat_max_o  <= lat_clr_i ? '0 : done && lat_n > lat_max_o ? lat_n : lat_max_o;
            overrun_o  <= !lat_clr_i && (overrun_o ||
                          (en_i && sample_valid_o && busy_o && !valid_strobe_out_i));
        end
    end
endmodule

// File: tb/tb_student_iis_frame_gen.sv
// tb_student_iis_frame_gen: randomized bench for two configurations against a frame-arithmetic model
module tb_student_iis_frame_gen;
    logic clk = 1'b0, rst_ni = 1'b1, en = 1'b0, vs = 1'b0, clr = 1'b0;

    logic d0_mclk, d0_bclk, d0_lrclk, d0_brise, d0_bfall, d0_lrise, d0_lfall, d0_sv, d0_busy, d0_ovr;
    logic [0:0]  d0_slot;
    logic [3:0]  d0_bit;
    logic [15:0] d0_last, d0_max;
    logic d1_mclk, d1_bclk, d1_lrclk, d1_brise, d1_bfall, d1_lrise, d1_lfall, d1_sv, d1_busy, d1_ovr;
    logic [1:0]  d1_slot;
    logic [4:0]  d1_bit;
    logic [15:0] d1_last, d1_max;

    student_iis_frame_gen dut0 (
        .clk_i(clk), .rst_ni(rst_ni), .en_i(en), .valid_strobe_out_i(vs), .lat_clr_i(clr),
        .ac_mclk_o(d0_mclk), .ac_bclk_o(d0_bclk), .ac_lrclk_o(d0_lrclk),
        .bclk_rise_o(d0_brise), .bclk_fall_o(d0_bfall), .lrclk_rise_o(d0_lrise), .lrclk_fall_o(d0_lfall),
        .slot_idx_o(d0_slot), .bit_idx_o(d0_bit), .sample_valid_o(d0_sv),
        .lat_last_o(d0_last), .lat_max_o(d0_max), .busy_o(d0_busy), .overrun_o(d0_ovr)
    );

    student_iis_frame_gen #(.DATA_SIZE(24), .SLOT_WIDTH(24), .NUM_SLOTS(4), .BCLK_DIV(4), .MCLK_DIV(4)) dut1 (
        .clk_i(clk), .rst_ni(rst_ni), .en_i(en), .valid_strobe_out_i(vs), .lat_clr_i(clr),
        .ac_mclk_o(d1_mclk), .ac_bclk_o(d1_bclk), .ac_lrclk_o(d1_lrclk),
        .bclk_rise_o(d1_brise), .bclk_fall_o(d1_bfall), .lrclk_rise_o(d1_lrise), .lrclk_fall_o(d1_lfall),
        .slot_idx_o(d1_slot), .bit_idx_o(d1_bit), .sample_valid_o(d1_sv),
        .lat_last_o(d1_last), .lat_max_o(d1_max), .busy_o(d1_busy), .overrun_o(d1_ovr)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int n = -1, cyc = 0;
    int t0[2], ml[2], mm[2];
    bit mb[2], mo[2];

    task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at n=%0d: got %0d expected %0d", nm, n, got, exp);
        end
    endtask

    function automatic int pbd(int i); return i != 0 ? 4 : 8; endfunction
    function automatic int pmd(int i); return i != 0 ? 4 : 2; endfunction
    function automatic int psw(int i); return i != 0 ? 24 : 16; endfunction
    function automatic int pns(int i); return i != 0 ? 4 : 2; endfunction

    // {mclk, bclk, lrclk, bclk_rise, bclk_fall, lrclk_rise, lrclk_fall, sample_valid} for enabled cycle k
    function automatic logic [7:0] flags(int i, int k);
        int bd, sw, ns, d, b, bp;
        logic lr, lrp;
        bd = pbd(i); sw = psw(i); ns = pns(i);
        if (k < 0) return 8'h00;
        d   = k % bd;
        b   = k / bd;
        bp  = (k - 1) / bd;
        lr  = ((b + 1) / sw) % ns >= ns / 2;
        lrp = k > 0 && ((bp + 1) / sw) % ns >= ns / 2;
        return {(k / (pmd(i) / 2)) % 2 == 0, d >= bd / 2, lr, d == bd / 2, d == 0 && k > 0,
                lr && !lrp, !lr && lrp, k > 0 && k % (bd * sw * ns) == 0};
    endfunction

    function automatic int bitidx(int i, int k);
        return k < 0 ? 0 : (k / pbd(i)) % psw(i);
    endfunction

    function automatic int slotidx(int i, int k);
        return k < 0 ? 0 : (k / pbd(i) / psw(i)) % pns(i);
    endfunction

    always @(posedge clk) begin : model
        logic [7:0] f;
        for (int i = 0; i < 2; i++) begin
            f = flags(i, n);
            if (!rst_ni) begin
                mb[i] = 0; mo[i] = 0; ml[i] = 0; mm[i] = 0;
            end else begin
                if (!en) mb[i] = 0;
                else begin
                    if (mb[i] && vs) begin
                        ml[i] = cyc - t0[i];
                        if (ml[i] > mm[i]) mm[i] = ml[i];
                    end
                    if (f[0]) begin
                        if (mb[i] && !vs) mo[i] = 1;
                        mb[i] = 1;
                        t0[i] = cyc;
                    end else if (mb[i] && vs) mb[i] = 0;
                end
                if (clr) begin ml[i] = 0; mm[i] = 0; mo[i] = 0; end
            end
        end
        n = !rst_ni ? -1 : en ? (n >= 0 ? n + 1 : 0) : -1;
        cyc++;
        #1;
        chk("d0_flags", {d0_mclk, d0_bclk, d0_lrclk, d0_brise, d0_bfall, d0_lrise, d0_lfall, d0_sv}, flags(0, n));
        chk("d0_bit", d0_bit, bitidx(0, n));
        chk("d0_slot", d0_slot, slotidx(0, n));
        chk("d0_last", d0_last, ml[0]);
        chk("d0_max", d0_max, mm[0]);
        chk("d0_busy", d0_busy, mb[0]);
        chk("d0_ovr", d0_ovr, mo[0]);
        chk("d1_flags", {d1_mclk, d1_bclk, d1_lrclk, d1_brise, d1_bfall, d1_lrise, d1_lfall, d1_sv}, flags(1, n));
        chk("d1_bit", d1_bit, bitidx(1, n));
        chk("d1_slot", d1_slot, slotidx(1, n));
        chk("d1_last", d1_last, ml[1]);
        chk("d1_max", d1_max, mm[1]);
        chk("d1_busy", d1_busy, mb[1]);
        chk("d1_ovr", d1_ovr, mo[1]);
    end

    task automatic goto_n(int t);
        int k = 0;
        do begin
            @(posedge clk);
            #2;
            k++;
        end while (n != t && k < 5000);
        chk("goto_n", n, t);
    endtask

    task automatic chk_zero(string nm);
        chk({nm, "_d0"}, {d0_mclk, d0_bclk, d0_lrclk, d0_brise, d0_bfall, d0_lrise, d0_lfall, d0_sv,
                          d0_bit, d0_slot, d0_last, d0_max, d0_busy, d0_ovr}, 0);
        chk({nm, "_d1"}, {d1_mclk, d1_bclk, d1_lrclk, d1_brise, d1_bfall, d1_lrise, d1_lfall, d1_sv,
                          d1_bit, d1_slot, d1_last, d1_max, d1_busy, d1_ovr}, 0);
    endtask

    initial begin
        #1 rst_ni = 1'b0;
        #2 chk_zero("reset");
        repeat (3) @(posedge clk);
        #2 rst_ni = 1'b1;
        en = 1'b1;
        goto_n(0);   chk("mclk0", d0_mclk, 1); chk("bclk0", d0_bclk, 0); chk("d1_mclk0", d1_mclk, 1);
        goto_n(1);   chk("mclk1", d0_mclk, 0); chk("d1_mclk1", d1_mclk, 1);
        goto_n(2);   chk("d1_mclk2", d1_mclk, 0);
        goto_n(4);   chk("brise4", d0_brise, 1); chk("bclk4", d0_bclk, 1); chk("d1_bfall4", d1_bfall, 1);
        goto_n(8);   chk("bfall8", d0_bfall, 1); chk("bit8", d0_bit, 1);
        goto_n(120); chk("lrise120", d0_lrise, 1); chk("lrclk120", d0_lrclk, 1); chk("bit120", d0_bit, 15);
        goto_n(188); chk("d1_lrise188", d1_lrise, 1); chk("d1_slot188", d1_slot, 1); chk("d1_bit188", d1_bit, 23);
        goto_n(248); chk("lfall248", d0_lfall, 1); chk("slot248", d0_slot, 1);
        goto_n(255); chk("sv255", d0_sv, 0);
        goto_n(256); chk("sv256", d0_sv, 1); chk("bit256", d0_bit, 0);
        goto_n(293); vs = 1'b1;
        goto_n(294); vs = 1'b0; chk("last37", d0_last, 37); chk("max37", d0_max, 37); chk("busy294", d0_busy, 0);
        goto_n(380); chk("d1_lfall380", d1_lfall, 1);
        goto_n(384); chk("d1_sv384", d1_sv, 1);
        goto_n(532); vs = 1'b1;
        goto_n(533); vs = 1'b0; chk("last20", d0_last, 20); chk("max_keep37", d0_max, 37);
        goto_n(1024); chk("ovr_before", d0_ovr, 0); chk("busy1024", d0_busy, 1);
        goto_n(1025); chk("ovr_set", d0_ovr, 1); clr = 1'b1;
        goto_n(1026); clr = 1'b0;
        chk("clr_ovr", d0_ovr, 0); chk("clr_max", d0_max, 0); chk("clr_last", d0_last, 0); chk("clr_busy", d0_busy, 1);

        for (int k = 0; k < 8000; k++) begin
            @(posedge clk);
            #2;
            vs  = ($urandom % 60) == 0;
            clr = ($urandom % 700) == 0;
            if (($urandom % 2500) == 0) en = ~en;
            if (!en && ($urandom % 50) == 0) en = 1'b1;
            if (($urandom % 3000) == 0) begin
                rst_ni = 1'b0;
                @(posedge clk);
                #2 rst_ni = 1'b1;
            end
        end

        vs = 1'b0; clr = 1'b0; en = 1'b1;
        rst_ni = 1'b0;
        @(posedge clk);
        #2 rst_ni = 1'b1;
        goto_n(256); chk("sv_after_rst", d0_sv, 1);
        goto_n(512); vs = 1'b1;
        goto_n(513); vs = 1'b0; chk("simul_last", d0_last, 256); chk("simul_ovr", d0_ovr, 0); chk("simul_busy", d0_busy, 1);
        goto_n(600); en = 1'b0;
        goto_n(-1);  chk("abort_busy", d0_busy, 0); chk("abort_last", d0_last, 256); chk("abort_bclk", d0_bclk, 0);
        en = 1'b1;
        goto_n(300); chk("busy300", d0_busy, 1);
        rst_ni = 1'b0;
        #1 chk_zero("async_rst");
        @(posedge clk);
        #2 rst_ni = 1'b1;
        goto_n(255); chk("sv255_post", d0_sv, 0);
        goto_n(256); chk("sv256_post", d0_sv, 1);
        repeat (2) @(posedge clk);
        #2 $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end
endmodule
